// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : Parametrised VGA timing generator. Walks the beam position
//             over the full (active + porch + sync) raster and produces
//             registered hsync/vsync/display_on together with per-pixel,
//             per-line and per-frame strobes and a completed-frame counter.
//  Ports    :
//    clk          in   system clock
//    rst          in   synchronous active-high reset
//    en           in   advance enable; low freezes all state
//    hpos         out  current pixel column   [POS_W]
//    vpos         out  current line           [POS_W]
//    display_on   out  beam inside the visible area
//    hsync        out  horizontal sync, active level HS_POL
//    vsync        out  vertical sync, active level VS_POL
//    pix_stb      out  one-clk pulse, position just advanced
//    line_start   out  one-clk pulse, position just became hpos=0
//    frame_start  out  one-clk pulse, position just became (0,0)
//    frame_cnt    out  completed-frame count, wraps [FRAME_W]
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 1,
  parameter int POS_W    = 10,
  parameter int FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [POS_W-1:0]   hpos,
  output logic [POS_W-1:0]   vpos,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               pix_stb,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  // --------------------------------------------------------------------------
  // Raster geometry, pre-sized to the position width so every compare below
  // is between equal-width operands.
  // --------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] H_LAST     = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST     = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS      = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_VIS      = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HS_START   = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HS_END     = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VS_START   = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VS_END     = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  // The divider needs at least one bit even when CLK_DIV=1; in that case it
  // simply sits at zero and every enabled clock is a tick.
  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div;

  // --------------------------------------------------------------------------
  // Next-position logic. Outputs are decoded from the *next* position and
  // registered together with it, so sync/display line up with hpos/vpos in
  // the same cycle without any pipeline skew.
  // --------------------------------------------------------------------------
  logic             tick;
  logic             h_wrap;
  logic             v_wrap;
  logic [POS_W-1:0] hpos_nxt;
  logic [POS_W-1:0] vpos_nxt;
  logic             disp_nxt;
  logic             hs_act_nxt;
  logic             vs_act_nxt;

  always_comb begin
    tick     = en && (div == DIV_LAST);
    h_wrap   = (hpos == H_LAST);
    v_wrap   = (vpos == V_LAST);

    hpos_nxt = h_wrap ? '0 : hpos + POS_W'(1);

    // vpos only moves when the line wraps, which also guarantees vsync only
    // ever changes at the start of a line.
    vpos_nxt = vpos;
    if (h_wrap) begin
      vpos_nxt = v_wrap ? '0 : vpos + POS_W'(1);
    end

    disp_nxt   = (hpos_nxt < H_VIS) && (vpos_nxt < V_VIS);
    hs_act_nxt = (hpos_nxt >= HS_START) && (hpos_nxt < HS_END);
    vs_act_nxt = (vpos_nxt >= VS_START) && (vpos_nxt < VS_END);
  end

  // --------------------------------------------------------------------------
  // Registers. Reset parks the beam on the last position of the raster so
  // the first tick after release lands on (0,0) and raises frame_start; the
  // frame counter starts at all-ones so that first frame reads zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      frame_cnt   <= '1;
      display_on  <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes are single-cycle; they default low and are raised on a tick.
      pix_stb     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;

      // The divider holds while en is low so a pause resumes mid-count.
      if (en) begin
        div <= tick ? '0 : div + DIV_W'(1);
      end

      if (tick) begin
        hpos        <= hpos_nxt;
        vpos        <= vpos_nxt;
        display_on  <= disp_nxt;
        hsync       <= hs_act_nxt ? HS_ACT : ~HS_ACT;
        vsync       <= vs_act_nxt ? VS_ACT : ~VS_ACT;
        pix_stb     <= 1'b1;
        line_start  <= h_wrap;
        frame_start <= h_wrap && v_wrap;
        if (h_wrap && v_wrap) begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Self-checking bench for vga_sync_gen. Four instances:
//             u_def  (defaults), u_div2 (CLK_DIV=2), u_div3 (CLK_DIV=3),
//             u_small (tiny raster, active-high syncs, 2-bit frame counter).
//             The small instance is checked through an expected-value queue
//             drained by a monitor on every pix_stb.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- default instance ----------------
  logic       rst0 = 1'b1, en0 = 1'b0;
  logic [9:0] hpos0, vpos0;
  logic       disp0, hs0, vs0, pix0, ls0, fs0;
  logic [7:0] fc0;
  vga_sync_gen u_def (
    .clk(clk), .rst(rst0), .en(en0), .hpos(hpos0), .vpos(vpos0),
    .display_on(disp0), .hsync(hs0), .vsync(vs0), .pix_stb(pix0),
    .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  // ---------------- CLK_DIV=2 instance ----------------
  logic       rst1 = 1'b1, en1 = 1'b0;
  logic [9:0] hpos1, vpos1;
  logic       disp1, hs1, vs1, pix1, ls1, fs1;
  logic [7:0] fc1;
  vga_sync_gen #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst1), .en(en1), .hpos(hpos1), .vpos(vpos1),
    .display_on(disp1), .hsync(hs1), .vsync(vs1), .pix_stb(pix1),
    .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  // ---------------- CLK_DIV=3 instance ----------------
  logic       rst3 = 1'b1, en3 = 1'b0;
  logic [9:0] hpos3, vpos3;
  logic       disp3, hs3, vs3, pix3, ls3, fs3;
  logic [7:0] fc3;
  vga_sync_gen #(.CLK_DIV(3)) u_div3 (
    .clk(clk), .rst(rst3), .en(en3), .hpos(hpos3), .vpos(vpos3),
    .display_on(disp3), .hsync(hs3), .vsync(vs3), .pix_stb(pix3),
    .line_start(ls3), .frame_start(fs3), .frame_cnt(fc3)
  );

  // ---------------- small raster: 7 x 6, active-high syncs ----------------
  logic       rst2 = 1'b1, en2 = 1'b0;
  logic [2:0] hpos2, vpos2;
  logic       disp2, hs2, vs2, pix2, ls2, fs2;
  logic [1:0] fc2;
  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CLK_DIV(1), .POS_W(3), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst(rst2), .en(en2), .hpos(hpos2), .vpos(vpos2),
    .display_on(disp2), .hsync(hs2), .vsync(vs2), .pix_stb(pix2),
    .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
  );

  // Packed view {hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt}
  function automatic logic [12:0] pk(input int h, input int v, input bit d, input bit hs,
                                     input bit vs, input bit ls, input bit fs, input int fc);
    logic [2:0] hh, vv;
    logic [1:0] ff;
    hh = h[2:0];
    vv = v[2:0];
    ff = fc[1:0];
    return {hh, vv, d, hs, vs, ls, fs, ff};
  endfunction

  logic [12:0] sb_q[$];
  bit          sb_on = 1'b0;

  // Expected beam sequence of the small raster, hand-derived from its
  // geometry: visible h<4 && v<3, hsync only at h=5, vsync only at v=4.
  task automatic push_frames(input int first_fc, input int nframes);
    for (int f = 0; f < nframes; f++)
      for (int v = 0; v < 6; v++)
        for (int h = 0; h < 7; h++)
          sb_q.push_back(pk(h, v, (h < 4) && (v < 3), h == 5, v == 4, h == 0,
                            (h == 0) && (v == 0), (first_fc + f) % 4));
    // first pixel of the following frame shows the incremented counter
    sb_q.push_back(pk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, (first_fc + nframes) % 4));
  endtask

  // Monitor: with en held high every cycle must carry a pix_stb, and each one
  // consumes one expected entry. Frame period is measured between frame_starts.
  int cyc = 0;
  int last_fs = -1;
  always @(negedge clk) begin
    logic [12:0] e;
    cyc++;
    if (!sb_on) begin
      last_fs = -1;
    end else if (!pix2) begin
      chk("sb_pix_stb_continuous", {31'd0, pix2}, 32'd1);
    end else if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_pixel: got pix_stb with empty queue, hpos=%0d vpos=%0d", hpos2, vpos2);
    end else begin
      e = sb_q.pop_front();
      chk("sb_beam", {19'd0, hpos2, vpos2, disp2, hs2, vs2, ls2, fs2, fc2}, {19'd0, e});
      if (fs2) begin
        if (last_fs >= 0) chk("sb_frame_period", cyc - last_fs, 42);
        last_fs = cyc;
      end
    end
  end

  task automatic drain(input string nm, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      if (sb_q.size() == 0) begin
        sb_on = 1'b0;
        done  = 1'b1;
      end
    end
    sb_on = 1'b0;
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int hs_cnt, hs_first, hs_last, disp_cnt, ls_cnt, pix_cnt;
    bit found;

    // ---------------- defaults: reset and first pixel ----------------
    rst0 = 1'b1; en0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hpos", hpos0, 799);
    chk("rst_vpos", vpos0, 524);
    chk("rst_display_on", disp0, 0);
    chk("rst_syncs", {hs0, vs0}, 2'b11);
    chk("rst_strobes", {pix0, ls0, fs0}, 0);
    chk("rst_frame_cnt", fc0, 8'hFF);
    rst0 = 1'b0;
    @(negedge clk);
    chk("first_pos", {hpos0, vpos0}, 0);
    chk("first_strobes", {pix0, ls0, fs0}, 3'b111);
    chk("first_frame_cnt", fc0, 0);
    chk("first_display_on", disp0, 1);

    // ---------------- defaults: one full line ----------------
    hs_cnt = 0; hs_first = -1; hs_last = -1; disp_cnt = 0; ls_cnt = 0; pix_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (hpos0 != 10'(i)) chk("line_hpos", hpos0, i);
      if (!hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hpos0);
        hs_last = int'(hpos0);
      end
      if (disp0) disp_cnt++;
      if (ls0)   ls_cnt++;
      if (pix0)  pix_cnt++;
      @(negedge clk);
    end
    chk("line_hsync_width", hs_cnt, 96);
    chk("line_hsync_first", hs_first, 656);
    chk("line_hsync_last", hs_last, 751);
    chk("line_display_cnt", disp_cnt, 640);
    chk("line_start_cnt", ls_cnt, 1);
    chk("line_pix_stb_cnt", pix_cnt, 800);
    chk("line2_pos", {hpos0, vpos0}, {10'd0, 10'd1});
    chk("line2_strobes", {ls0, fs0, vs0}, 3'b101);

    // ---------------- CLK_DIV=2: pix_stb alternates ----------------
    rst1 = 1'b1; en1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("div2_rst", {pix1, hpos1}, {1'b0, 10'd799});
    rst1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("div2_pix_stb", pix1, (i % 2 == 1) ? 1 : 0);
      chk("div2_hpos", hpos1, (i == 0) ? 799 : (i - 1) / 2);
    end

    // ---------------- CLK_DIV=3: pause preserves divider ----------------
    rst3 = 1'b1; en3 = 1'b1;
    repeat (2) @(negedge clk);
    rst3 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (pix3 && hpos3 == 10'd100) found = 1'b1;
    end
    chk("pause_reach_hpos100", {31'd0, found}, 1);
    @(negedge clk);                       // one en-cycle into the divider
    chk("pause_pre", {pix3, hpos3}, {1'b0, 10'd100});
    en3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pause_frozen",
          {hpos3, vpos3, disp3, hs3, vs3, pix3, ls3, fs3, fc3},
          {10'd100, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    en3 = 1'b1;
    @(negedge clk);
    chk("pause_resume_1", {pix3, hpos3}, {1'b0, 10'd100});
    @(negedge clk);
    chk("pause_resume_tick", {pix3, hpos3}, {1'b1, 10'd101});

    // ---------------- small raster: five frames through the scoreboard ----
    rst2 = 1'b1; en2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("small_rst", {pix2, hpos2, vpos2, disp2, hs2, vs2, ls2, fs2, fc2},
        {1'b0, pk(6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3)});
    push_frames(0, 5);
    rst2 = 1'b0;
    @(posedge clk);
    sb_on = 1'b1;
    drain("small_drain", 400);

    // ---------------- small raster: reset mid-frame ----------------
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (hpos2 == 3'd3 && vpos2 == 3'd2) found = 1'b1;
    end
    chk("midrst_reach", {31'd0, found}, 1);
    rst2 = 1'b1;
    @(negedge clk);
    chk("midrst_values", {pix2, hpos2, vpos2, disp2, hs2, vs2, ls2, fs2, fc2},
        {1'b0, pk(6, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3)});
    push_frames(0, 1);
    rst2 = 1'b0;
    @(posedge clk);
    sb_on = 1'b1;
    drain("midrst_drain", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Parametrised VGA timing generator for the TinyTapeout VGA game designs, including the crossyroad top.
- Produces hsync, vsync and display_on, plus the current beam position and per-pixel, line and frame strobes, for the game's pixel logic.
- Generalises the fixed 640x480 generator: configurable porch and sync widths, sync polarity, a clock-to-pixel divider, a pause input and a frame counter.
- Sits directly under the tt_um_* top; uo_out carries the sync and colour outputs.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- POS_W, 10, width of hpos/vpos (must hold H_TOTAL-1 and V_TOTAL-1)
- FRAME_W, 8, width of frame_cnt

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  advance enable; low freezes all state
- hpos  out  POS_W  current pixel column
- vpos  out  POS_W  current line
- display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- pix_stb  out  1  one-clk pulse: position just advanced
- line_start  out  1  one-clk pulse: position just became hpos=0
- frame_start  out  1  one-clk pulse: position just became (0,0)
- frame_cnt  out  FRAME_W  completed-frame count, wraps

Behaviour:
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise (defaults 800 and 525).
- Reset (rst=1 on a clk edge) has priority over en and applies mid-frame:
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1, divider=0, frame_cnt=all-ones.
  - display_on=0, hsync=!HS_POL, vsync=!VS_POL, all strobes 0.
- Divider:
  - div counts 0..CLK_DIV-1 on clk edges where en=1, then wraps; it holds when en=0.
  - tick = en && div==CLK_DIV-1. With CLK_DIV=1, tick=en.
- On a tick, position advances:
  - hpos+1; at H_TOTAL-1, hpos wraps to 0 and vpos+1.
  - At (H_TOTAL-1, V_TOTAL-1) the position wraps to (0,0) and frame_cnt+1 (modulo 2^FRAME_W). The first frame after reset therefore reads frame_cnt=0.
- All outputs are registered and describe the current hpos/vpos in the same cycle (zero skew):
  - hsync is active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC. vsync changes at hpos=0 only.
  - display_on is as defined under Ports.
- Strobes are high exactly one clk, in the cycle after a tick edge (the cycle hpos/vpos show the new value):
  - pix_stb on every tick.
  - line_start when the new hpos=0.
  - frame_start when the new position is (0,0). frame_cnt shows its incremented value in the same cycle.
- en=0: nothing changes and strobes are 0. en deasserting mid-divider resumes the count from where it stopped.
- Back-to-back: with CLK_DIV=1 and en=1 held, pix_stb stays high continuously.
- No internal state other than the divider, positions, frame_cnt and registered outputs.
- Parameter misuse (CLK_DIV=0, POS_W too small) is outside scope. The bench covers only legal values.

Test Plan:
- Reset: hold rst=1 for 3 clk with en=1 (defaults) → hpos=799, vpos=524, display_on=0, hsync=vsync=1, strobes 0, frame_cnt=8'hFF.
  - Release → next clk: hpos=0, vpos=0, pix_stb=line_start=frame_start=1, frame_cnt=0, display_on=1.
- Full frame, defaults, en=1 → frame_start pulses exactly every 420000 clk.
  - hsync low only for hpos 656..751 (96 clk per line).
  - vsync low only for vpos 490..491 (1600 clk).
  - display_on count per frame = 307200.
- CLK_DIV=2, defaults otherwise → pix_stb alternates 0/1.
  - hpos advances every 2 clk; frame period 840000 clk.
- Pause: with CLK_DIV=3, drop en for 5 clk at hpos=100 → all outputs frozen, strobes 0.
  - On resume, the tick falls 3 en-cycles after the last tick (the divider count is preserved).
- Reset mid-frame at vpos=200, hpos=300 → next cycle shows the reset values; frame_cnt restarts at 0 on the following frame_start.
- Small config: H 4/1/1/1, V 3/1/1/1, HS_POL=VS_POL=1, FRAME_W=2.
  - Frame period 42 clk; hsync high only at hpos=5; vsync high only at vpos=4.
  - frame_cnt sequence 0,1,2,3,0.
